nios_debug_cmd_sequencer: RTL and testbench
===========================================

NIOS_DEBUG_CMD_SEQUENCER -- requirements
Module: nios_debug_cmd_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, debug-RAM word-address width.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles mem_req waits for mem_ack (1..1023).
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  one-cycle pulse: command captured (synchronized update-DR).
REQ-006 cmd_ir  in  2  instruction code accompanying command.
REQ-007 cmd_jdo  in  38  command word.
REQ-008 mem_req  out  1  memory access request, held until ack or timeout.
REQ-009 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  out  ADDR_W  access word address.
REQ-011 mem_wdata  out  32  write data.
REQ-012 mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle.
REQ-013 mem_rdata  in  32  read data.
REQ-014 MonDReg  out  32  last read data returned to debugger.
REQ-015 monitor_ready  out  1  level: last accepted command complete.
REQ-016 monitor_error  out  1  level: sticky error (timeout or overrun).
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States IDLE, REQ, DONE; enum encoding.
REQ-019 Only cmd_ir == 2'b00 (OCIMEM) is acted on; other codes are ignored, with no state, flag or address change.
REQ-020 Decode of accepted OCIMEM command: jdo[37]=1 -> SET_ADDR, address register <= jdo[ADDR_W-1:0], no memory access; jdo[37:36]=01 -> WRITE jdo[31:0]; jdo[37:36]=00 -> READ.
REQ-021 SET_ADDR in IDLE completes in one cycle: monitor_ready=1 next cycle, state stays IDLE.
REQ-022 READ/WRITE accepted in IDLE at cycle N: monitor_ready cleared, monitor_error cleared, state REQ, mem_req=1 at N+1.
REQ-023 mem_addr, mem_we, mem_wdata stable throughout mem_req.
REQ-024 mem_ack sampled at cycle M in REQ: mem_req=0 at M+1, state DONE at M+1; on READ MonDReg <= mem_rdata at M+1; address register increments by 1 modulo 2^ADDR_W (all-ones wraps to zero).
REQ-025 DONE lasts exactly one cycle: monitor_ready=1, then IDLE.
REQ-026 Timeout: TIMEOUT cycles in REQ without mem_ack -> mem_req=0, monitor_error=1, monitor_ready=1, MonDReg and address unchanged, state IDLE.
REQ-027 mem_ack outside REQ is ignored.
REQ-028 cmd_valid while busy (including the cycle mem_ack arrives, and DONE) is dropped; monitor_error set; in-progress access unaffected.
REQ-029 Timeout counter clears on every entry to REQ.

Reset
REQ-030 reset_n low asynchronously forces IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MonDReg=0, monitor_ready=1, monitor_error=0, busy=0, address register=0, timeout counter=0.
REQ-031 Reset mid-access drops mem_req immediately; the access counts as never issued.

Structure
REQ-032 Shared package dbg_seq_pkg holds the state enum, the OCIMEM IR constant, and the jdo field bit positions (37, 36, 31:0).
REQ-033 One sub-module dbg_seq_timer: clear/enable counter, width ceil(log2(TIMEOUT+1)), expired flag.

Verification
REQ-034 SET_ADDR jdo[7:0]=0x10, then READ; mem_rdata=0xDEADBEEF on ack at 3rd REQ cycle -> mem_addr=0x10, MonDReg=0xDEADBEEF, address 0x11, monitor_ready=1.
REQ-035 SET_ADDR 0xFF, WRITE 0x12345678 -> mem_we=1, mem_addr=0xFF, mem_wdata=0x12345678; after ack address wraps to 0x00.
REQ-036 READ, no ack for 255 cycles -> mem_req falls on cycle after 255th, monitor_error=1, MonDReg unchanged, address unchanged.
REQ-037 Second cmd_valid in the same cycle as mem_ack -> second command dropped, monitor_error=1, first read data correctly in MonDReg.
REQ-038 cmd_ir=2'b01 with READ encoding -> no mem_req, flags unchanged.
REQ-039 reset_n low during REQ -> mem_req=0 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/dbg_seq_pkg.sv
// Shared definitions for the debug command sequencer.
//   state_t          : sequencer FSM states
//   IR_OCIMEM        : the only instruction code the sequencer acts on
//   JDO_* positions  : field layout of the 38-bit command word
package dbg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] IR_OCIMEM = 2'b00;

    // jdo[37]=1 selects SET_ADDR; otherwise jdo[36] picks write (1) or read (0).
    localparam int JDO_SET_ADDR_BIT = 37;
    localparam int JDO_WRITE_BIT    = 36;
    localparam int JDO_DATA_MSB     = 31;
    localparam int JDO_DATA_LSB     = 0;

endpackage

// File: rtl/dbg_seq_timer.sv
// Access timeout counter.
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : synchronous clear (held while not waiting on memory)
//   enable       : count one cycle of waiting
//   expired      : high during the TIMEOUT-th enabled cycle
module dbg_seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // The count holds the number of completed waiting cycles, so the
    // TIMEOUT-th waiting cycle sees cnt == TIMEOUT-1.
    assign expired = enable && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios_debug_cmd_sequencer.sv
// Debug command sequencer: turns synchronized JTAG update-DR commands into
// single-word debug-RAM accesses with an auto-incrementing address.
//   cmd_valid/cmd_ir/cmd_jdo : one-cycle command pulse, IR code, command word
//   mem_req/mem_we/mem_addr/mem_wdata : access request, held until ack/timeout
//   mem_ack/mem_rdata        : one-cycle completion and read data
//   MonDReg                  : last read data returned to the debugger
//   monitor_ready/_error     : command complete / sticky timeout-or-overrun
//   busy                     : sequencer not idle
module nios_debug_cmd_sequencer
    import dbg_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_ir,
    input  logic [37:0]       cmd_jdo,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              timer_expired;
    logic              cmd_ocimem;

    // Bits 35:32 carry no meaning for OCIMEM commands.
    logic unused_jdo;
    assign unused_jdo = ^cmd_jdo[35:32];

    assign cmd_ocimem = cmd_valid && (cmd_ir == IR_OCIMEM);
    assign busy       = (state != ST_IDLE);

    // Counter is held clear outside REQ, so it restarts at zero on every entry.
    dbg_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ST_REQ),
        .enable  (state == ST_REQ),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_ocimem) begin
                        if (cmd_jdo[JDO_SET_ADDR_BIT]) begin
                            addr_q        <= cmd_jdo[ADDR_W-1:0];
                            monitor_ready <= 1'b1;
                        end else begin
                            // Access fields are latched once so they stay
                            // stable for the whole request.
                            mem_we        <= cmd_jdo[JDO_WRITE_BIT];
                            mem_addr      <= addr_q;
                            if (cmd_jdo[JDO_WRITE_BIT]) begin
                                mem_wdata <= cmd_jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                            end
                            mem_req       <= 1'b1;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            state         <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    // Any command arriving mid-access is an overrun.
                    if (cmd_valid) begin
                        monitor_error <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        monitor_ready <= 1'b1;
                        addr_q        <= addr_q + ADDR_W'(1);
                        if (!mem_we) begin
                            MonDReg <= mem_rdata;
                        end
                        state <= ST_DONE;
                    end else if (timer_expired) begin
                        mem_req       <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_DONE: begin
                    if (cmd_valid) begin
                        monitor_error <= 1'b1;
                    end
                    monitor_ready <= 1'b1;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_debug_cmd_sequencer.sv
// Directed, scoreboarded bench for nios_debug_cmd_sequencer (ADDR_W=8,
// TIMEOUT=255). Expected accesses and read data are queued when commands
// are issued and compared when the DUT presents them.
module tb_nios_debug_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_jdo = '0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    nios_debug_cmd_sequencer #(
        .ADDR_W  (8),
        .TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ir        (cmd_ir),
        .cmd_jdo       (cmd_jdo),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .MonDReg       (MonDReg),
        .monitor_ready (monitor_ready),
        .monitor_error (monitor_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_mon[$];
    logic [7:0]  model_addr = 8'h00;
    logic [31:0] model_mon  = 32'h0;
    logic        cur_we     = 1'b0;
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_fail     = 0;

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one rising edge; returns at the
    // falling edge after that edge.
    task automatic send(input logic [1:0] ir, input logic [37:0] jdo);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_jdo   = jdo;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_jdo   = '0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        send(2'b00, {1'b1, 29'b0, a});
        model_addr = a;
        check("set_addr_ready", monitor_ready, 1);
        check("set_addr_busy", busy, 0);
        check("set_addr_no_req", mem_req, 0);
    endtask

    // Issue READ/WRITE, then pop the scoreboard when the request is visible.
    task automatic start_access(input logic we, input logic [31:0] wd);
        acc_t e;
        exp_acc.push_back('{we: we, addr: model_addr, wdata: wd});
        cur_we = we;
        send(2'b00, {1'b0, we, 4'b0, wd});
        check("req_high", mem_req, 1);
        check("req_busy", busy, 1);
        check("req_ready_clr", monitor_ready, 0);
        check("req_error_clr", monitor_error, 0);
        e = exp_acc.pop_front();
        check("req_we", mem_we, e.we);
        check("req_addr", mem_addr, e.addr);
        if (e.we) check("req_wdata", mem_wdata, e.wdata);
    endtask

    // Called at the falling edge of REQ cycle 1; acks in REQ cycle 'cyc'.
    task automatic ack_at(input int cyc, input logic [31:0] rd);
        logic [7:0] a0;
        a0 = mem_addr;
        for (int i = 1; i < cyc; i++) begin
            @(negedge clk);
            check("req_held", mem_req, 1);
            check("addr_stable", mem_addr, a0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        model_addr = model_addr + 8'd1;
        if (!cur_we) begin
            model_mon = rd;
            exp_mon.push_back(rd);
        end
        check("ack_req_low", mem_req, 0);
        check("done_busy", busy, 1);
        check("done_ready", monitor_ready, 1);
        if (!cur_we) check("mondreg_read", MonDReg, exp_mon.pop_front());
        else         check("mondreg_keep", MonDReg, model_mon);
        @(negedge clk);
        check("idle_after_done", busy, 0);
        check("idle_ready", monitor_ready, 1);
    endtask

    initial begin
        int c;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", monitor_ready, 1);
        check("rst_error", monitor_error, 0);
        check("rst_mondreg", MonDReg, 0);
        check("rst_addr", mem_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // SET_ADDR 0x10, READ acked in 3rd REQ cycle
        set_addr(8'h10);
        start_access(1'b0, 32'h0);
        ack_at(3, 32'hDEAD_BEEF);

        // Auto-increment: next READ must hit 0x11
        start_access(1'b0, 32'h0);
        ack_at(1, 32'hCAFE_F00D);

        // SET_ADDR 0xFF, WRITE, then address wraps to 0x00
        set_addr(8'hFF);
        start_access(1'b1, 32'h1234_5678);
        ack_at(2, 32'hFFFF_FFFF);
        start_access(1'b0, 32'h0);
        ack_at(1, 32'h0000_0001);

        // Timeout: READ with no ack
        start_access(1'b0, 32'h0);
        c = 0;
        while (mem_req === 1'b1 && c < 300) begin
            c++;
            @(negedge clk);
        end
        check("timeout_cycles", c, 255);
        check("timeout_error", monitor_error, 1);
        check("timeout_ready", monitor_ready, 1);
        check("timeout_idle", busy, 0);
        check("timeout_mondreg", MonDReg, model_mon);
        // Address unchanged: scoreboard expects the same address again
        start_access(1'b0, 32'h0);
        ack_at(1, 32'h2468_ACE0);

        // Overrun: second command in the same cycle as mem_ack
        start_access(1'b0, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        cmd_valid = 1'b1;
        cmd_ir    = 2'b00;
        cmd_jdo   = {2'b01, 4'b0, 32'hAAAA_5555};
        @(negedge clk);
        mem_ack   = 1'b0;
        cmd_valid = 1'b0;
        cmd_jdo   = '0;
        model_addr = model_addr + 8'd1;
        model_mon  = 32'h0BAD_F00D;
        check("overrun_error", monitor_error, 1);
        check("overrun_mondreg", MonDReg, model_mon);
        check("overrun_req_low", mem_req, 0);
        @(negedge clk);
        check("overrun_idle", busy, 0);
        @(negedge clk);
        check("overrun_no_req", mem_req, 0);

        // Non-OCIMEM IR ignored; stray ack ignored
        send(2'b01, 38'h0);
        check("ir01_no_req", mem_req, 0);
        check("ir01_busy", busy, 0);
        check("ir01_ready", monitor_ready, 1);
        check("ir01_error_kept", monitor_error, 1);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack   = 1'b0;
        check("stray_ack_mondreg", MonDReg, model_mon);
        check("stray_ack_busy", busy, 0);
        start_access(1'b0, 32'h0);
        ack_at(2, 32'h1357_9BDF);

        // Asynchronous reset during REQ
        start_access(1'b0, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_mondreg", MonDReg, 0);
        check("arst_ready", monitor_ready, 1);
        check("arst_error", monitor_error, 0);
        check("arst_busy", busy, 0);
        model_addr = 8'h00;
        model_mon  = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_access(1'b0, 32'h0);
        ack_at(1, 32'h7777_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
